// File: rtl/seq_restoring_divider_pkg.sv
// Shared state encoding and constants for the sequential restoring divider.
package seq_restoring_divider_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_DONE  = 2'd2,
        ST_FIXUP = 2'd3
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

    // Sliced down to WIDTH by the user; all ones at any width.
    localparam logic [63:0] DZ_QUOTIENT = '1;

endpackage

// File: rtl/seq_restoring_divider_addsub_ripple.sv
// Ripple-carry add/subtract unit: o_sum = i_a + (i_sub ? ~i_b + 1 : i_b).
module addsub_ripple #(
    parameter int N = 9
) (
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    input  logic         i_sub,
    output logic [N-1:0] o_sum
);

    logic [N-1:0] w_b;
    logic [N-1:0] w_c;

    assign w_b    = i_b ^ {N{i_sub}};
    assign w_c[0] = i_sub;

    for (genvar i = 0; i < N; i++) begin : g_fa
        assign o_sum[i] = i_a[i] ^ w_b[i] ^ w_c[i];
        // The carry out of the top bit is never consumed, so the chain stops there.
        if (i < N - 1) begin : g_carry
            assign w_c[i+1] = (i_a[i] & w_b[i]) | (w_c[i] & (i_a[i] ^ w_b[i]));
        end
    end

endmodule

// File: rtl/seq_restoring_divider.sv
// Sequential restoring divider, one shift-subtract-restore step per clock.
// Define SIGNED_DIV_EN for two's-complement operands (adds a FIXUP state).
module seq_restoring_divider
    import seq_restoring_divider_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t           r_state;
    logic [WIDTH:0]   r_a;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_m;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_rem;
    logic             r_busy;
    logic             r_done;
    logic             r_dz;
    logic             r_dz_pend;

    logic [WIDTH:0]   w_a_sh;
    logic [WIDTH-1:0] w_q_sh;
    logic [WIDTH:0]   w_add_a;
    logic [WIDTH:0]   w_add_b;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_q_load;
    logic [WIDTH-1:0] w_m_load;

`ifdef SIGNED_DIV_EN
    logic r_neg_q;
    logic r_neg_r;

    assign w_q_load = dividend[WIDTH-1] ? (~dividend + WIDTH'(1)) : dividend;
    assign w_m_load = divisor[WIDTH-1]  ? (~divisor + WIDTH'(1))  : divisor;
`else
    // A never exceeds M after a restore, so its top bit is only a sign for the trial subtract.
    logic w_unused_a_msb;
    assign w_unused_a_msb = r_a[WIDTH];

    assign w_q_load = dividend;
    assign w_m_load = divisor;
`endif

    assign w_a_sh = {r_a[WIDTH-1:0], r_q[WIDTH-1]};
    assign w_q_sh = {r_q[WIDTH-2:0], ~w_sum[WIDTH]};

    always_comb begin
        w_add_a = w_a_sh;
        w_add_b = {1'b0, r_m};
`ifdef SIGNED_DIV_EN
        // The adder is idle outside the iteration, so it doubles as the negator.
        if (r_state == ST_FIXUP) begin
            w_add_a = '0;
            w_add_b = r_a;
        end else if (r_state == ST_BUSY && r_cnt == '0) begin
            w_add_a = '0;
            w_add_b = {1'b0, r_q};
        end
`endif
    end

    addsub_ripple #(.N(WIDTH + 1)) u_addsub (
        .i_a   (w_add_a),
        .i_b   (w_add_b),
        .i_sub (1'b1),
        .o_sum (w_sum)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_a       <= '0;
            r_q       <= '0;
            r_m       <= '0;
            r_cnt     <= '0;
            r_quot    <= '0;
            r_rem     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_dz      <= 1'b0;
            r_dz_pend <= 1'b0;
`ifdef SIGNED_DIV_EN
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_m     <= w_m_load;
                        r_dz    <= 1'b0;
                        r_state <= ST_BUSY;
`ifdef SIGNED_DIV_EN
                        r_neg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                        r_neg_r <= dividend[WIDTH-1];
`endif
                        // Divide by zero parks the final values in A/Q and skips iteration.
                        if (divisor == '0) begin
                            r_q       <= DZ_QUOTIENT[WIDTH-1:0];
                            r_a       <= {1'b0, dividend};
                            r_cnt     <= '0;
                            r_dz_pend <= 1'b1;
                            r_busy    <= 1'b0;
                        end else begin
                            r_q       <= w_q_load;
                            r_a       <= '0;
                            r_cnt     <= CNT_W'(WIDTH);
                            r_dz_pend <= 1'b0;
                            r_busy    <= 1'b1;
                        end
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end

                ST_BUSY: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CNT_W'(1);
                        r_q   <= w_q_sh;
                        r_a   <= w_sum[WIDTH] ? w_a_sh : w_sum;
                        if (r_cnt == CNT_W'(1)) begin
                            r_busy <= 1'b0;
                        end
                    end
`ifdef SIGNED_DIV_EN
                    else if (!r_dz_pend) begin
                        if (r_neg_q) begin
                            r_q <= w_sum[WIDTH-1:0];
                        end
                        r_state <= ST_FIXUP;
                    end
`endif
                    else begin
                        r_quot  <= r_q;
                        r_rem   <= r_a[WIDTH-1:0];
                        r_dz    <= r_dz_pend;
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end
                end

`ifdef SIGNED_DIV_EN
                ST_FIXUP: begin
                    r_quot  <= r_q;
                    r_rem   <= r_neg_r ? w_sum[WIDTH-1:0] : r_a[WIDTH-1:0];
                    r_done  <= 1'b1;
                    r_state <= ST_DONE;
                end
`endif

                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign quotient    = r_quot;
    assign remainder   = r_rem;
    assign busy        = r_busy;
    assign done        = r_done;
    assign div_by_zero = r_dz;

endmodule
